// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: round count, state type, FSM
// encoding, GF(2^8) helpers and the byte-permutation / column-mixing
// functions used by the datapath.
package aes_pkg;

  localparam int NR = 10;

  // Byte 0 sits in [127:120]; byte i maps to row i%4, column i/4.
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r is rotated right by r bytes: out[r][c] = in[r][(c - r) mod 4].
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {0e,0b,0d,09}.
  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                           mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                           mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                           mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Table lookup.
  assign y_o = TBL[a_i];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys pulled
// combinationally from an external key store via rk_idx/rk_in.
// Optional feature: define AES_INV_ABORT_EN to add the abort input.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; once out_valid rises, it and
// pt_out stay stable until the edge on which out_ready is high.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  fsm_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t data_q, data_d;
  aes_state_t shifted, sub_bytes, round_xor;
  logic       abort_w;

`ifdef AES_INV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // InvShiftRows then InvSubBytes (16 parallel lookups), then AddRoundKey.
  assign shifted = inv_shift_rows(data_q);
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .a_i (shifted[127-8*g -: 8]),
      .y_o (sub_bytes[127-8*g -: 8])
    );
  end
  assign round_xor = sub_bytes ^ rk_in;

  assign pt_out = data_q;

  // Next-state, round datapath select and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = 4'd0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = 4'(NR);
        if (in_valid) begin
          data_d  = ct_in ^ rk_in;
          cnt_d   = 4'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = cnt_q;
        data_d = inv_mix_columns(round_xor);
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        rk_idx  = cnt_q;
        data_d  = round_xor;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      data_d  = '0;
    end
  end

  // State, round counter and data register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: a forward AES-128 model (S-box derived from
// GF(2^8) inversion) produces ciphertexts, a timeline model predicts the
// handshake outputs every cycle, and a scoreboard queue holds plaintexts.
// Build with +define+AES_INV_ABORT_EN to exercise the abort input.
`timescale 1ns/1ps
module tb_aes_inv_cipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ct_in = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] pt_out;
  logic         busy;
  logic         abort = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;
  int acc_cyc = 0;
  int out_cyc = 0;

  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_tbl [11];

  bit           m_idle = 1'b1;
  int           m_age = 0;
  logic [127:0] m_pt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  // External key store.
  assign rk_in = (rk_idx <= 4'd10) ? rk_tbl[rk_idx] : 128'h0;

  // Consumer: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  // ---------------- forward AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tbl[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk_tbl[rnd][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- timeline model + compare ----------------
  // Accept edge, then 10 edges to out_valid; rk_idx counts 9..0 meanwhile.
  always @(negedge clk) begin
    logic [3:0] e_rk;
    if (!rst_n) begin
      m_idle = 1'b1;
      m_age  = 0;
    end
    e_rk = m_idle ? 4'd10 : (m_age >= 9 ? 4'd0 : 4'(9 - m_age));
    chk("in_ready", in_ready, m_idle);
    chk("busy", busy, !m_idle);
    chk("out_valid", out_valid, !m_idle && m_age >= 10);
    chk("rk_idx", rk_idx, e_rk);
    if (!m_idle && m_age >= 10) chk("pt_out", pt_out, m_pt);
    if (rst_n) begin
      if (abort) begin
        m_idle = 1'b1;
      end else if (m_idle) begin
        if (in_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_unexpected: got accept with empty scoreboard (t=%0t)", $time);
            m_pt = 'x;
          end else begin
            m_pt = exp_q.pop_front();
          end
          m_idle = 1'b0;
          m_age  = 0;
        end
      end else if (m_age >= 10) begin
        if (out_ready) m_idle = 1'b1;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    in_valid = 1'b1;
    ct_in    = ct;
    exp_q.push_back(pt);
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("send_accept");
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    if (n >= 40) timeout(name);
    out_cyc = cyc;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (n >= 300) timeout("wait_ready");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [127:0] pt, ct, pt_b, ct_b;

    build_sbox();
    chk("model_sbox_00", sbox_t[8'h00], 8'h63);
    chk("model_sbox_53", sbox_t[8'h53], 8'hed);
    set_key(C1_KEY);
    chk("model_c1_rk10", rk_tbl[10], C1_RK10);
    chk("model_c1_ct", encrypt(C1_PT), C1_CT);

    // reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pt_out", pt_out, 128'h0);
    chk("rst_rk_idx", rk_idx, 4'd10);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);

    // FIPS-197 C.1
    send(C1_CT, C1_PT);
    wait_out("c1_out");
    chk("c1_latency", 128'(out_cyc - acc_cyc), 128'd10);
    chk("c1_pt", pt_out, C1_PT);
    wait_ready();

    // all-zero key with backpressure
    set_key(128'h0);
    chk("model_zero_ct", encrypt(128'h0), Z_CT);
    ready_mode = 0;
    send(Z_CT, 128'h0);
    wait_out("zero_out");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_pt_held", pt_out, 128'h0);
      tick();
    end
    ready_mode = 1;
    tick();
    chk("bp_exit_in_ready", in_ready, 1'b1);
    chk("bp_exit_out_valid", out_valid, 1'b0);

    // in_valid held high across an operation
    set_key(rand128());
    pt = rand128();   ct = encrypt(pt);
    pt_b = rand128(); ct_b = encrypt(pt_b);
    in_valid = 1'b1;
    ct_in    = ct;
    exp_q.push_back(pt);
    tick();
    ct_in = ct_b;
    exp_q.push_back(pt_b);
    wait_out("hold_first");
    chk("hold_first_pt", pt_out, pt);
    tick();
    wait_out("hold_second");
    chk("hold_second_pt", pt_out, pt_b);
    in_valid = 1'b0;
    wait_ready();

    // asynchronous reset mid-operation at cnt=5
    set_key(C1_KEY);
    send(C1_CT, C1_PT);
    n = 0;
    while (rk_idx != 4'd5 && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("rst_wait_cnt5");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pt_out", pt_out, 128'h0);
    chk("arst_rk_idx", rk_idx, 4'd10);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("arst_no_out", out_valid, 1'b0);
    end
    send(C1_CT, C1_PT);
    wait_out("arst_c1_out");
    chk("arst_c1_pt", pt_out, C1_PT);
    wait_ready();

`ifdef AES_INV_ABORT_EN
    // abort at cnt=3
    set_key(rand128());
    pt = rand128();
    send(encrypt(pt), pt);
    n = 0;
    while (rk_idx != 4'd3 && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("abort_wait_cnt3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_pt_cleared", pt_out, 128'h0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_out", out_valid, 1'b0);
      tick();
    end
    pt = rand128();
    send(encrypt(pt), pt);
    wait_out("abort_next_out");
    chk("abort_next_pt", pt_out, pt);
    wait_ready();
`endif

    // randomized blocks, keys and consumer stalls
    ready_mode = 2;
    for (int b = 0; b < 12; b++) begin
      if (b % 3 == 0) set_key(rand128());
      pt = rand128();
      ct = encrypt(pt);
      repeat ($urandom_range(0, 3)) tick();
      send(ct, pt);
      wait_out("rand_out");
      chk("rand_pt", pt_out, pt);
      wait_ready();
    end
    ready_mode = 1;
    repeat (3) tick();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: ciphertext offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept ciphertext.
REQ-006 SHALL have port ct_in, input, 128 bits: ciphertext, FIPS-197 byte order (byte 0 = [127:120], column-major state).
REQ-007 SHALL have port rk_idx, output, 4 bits: index (0..10) of the requested round key.
REQ-008 SHALL have port rk_in, input, 128 bits: round key rk_idx, supplied combinationally by an external key store and valid in the same cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: plaintext valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts plaintext.
REQ-011 SHALL have port pt_out, output, 128 bits: plaintext, same byte order as ct_in.
REQ-012 SHALL have port busy, output, 1 bit: high in all FSM states except IDLE.

Function
REQ-013 SHALL use FSM states IDLE, ROUND, FINAL and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid in any other state SHALL be ignored.
REQ-015 SHALL drive rk_idx: 10 in IDLE; the value of round counter cnt in ROUND and FINAL; 0 in DONE.
REQ-016 SHALL, on an edge with in_valid&in_ready: set state <= ct_in ^ rk_in (rk10), set cnt <= 9, and go to ROUND.
REQ-017 SHALL, in ROUND: set state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_in) and decrement cnt; after processing cnt=1, go to FINAL with cnt=0.
REQ-018 SHALL, in FINAL: set state <= InvSubBytes(InvShiftRows(state)) ^ rk_in (rk0) and go to DONE.
REQ-019 SHALL apply InvShiftRows as a cyclic right rotation of row r by r bytes (r=0..3).
REQ-020 SHALL apply InvMixColumns per column with coefficients {0e,0b,0d,09} over GF(2^8) with polynomial 0x11b.
REQ-021 SHALL raise out_valid exactly 10 clock edges after the accepting edge (9 ROUND edges plus 1 FINAL edge).
REQ-022 SHALL drive pt_out from the state register and keep it stable while out_valid=1.
REQ-023 SHALL hold DONE while out_ready=0.
REQ-024 SHALL go from DONE to IDLE on an edge with out_ready=1; the next accept SHALL take place no earlier than the following edge.
REQ-025 SHALL treat an out_ready asserted before DONE as having no effect.

Reset
REQ-026 SHALL, while rst_n=0: state=IDLE, cnt=0, state register=0, out_valid=0, in_ready=1 (after deassertion), busy=0, pt_out=0, rk_idx=10.
REQ-027 SHALL discard any in-flight block on reset assertion mid-operation; no out_valid SHALL follow for that block.

Configuration
REQ-028 SHALL, with macro AES_INV_ABORT_EN defined, add an input port abort (1 bit); abort=1 on any edge SHALL force IDLE, clear out_valid and clear the state register; abort SHALL take priority over accept and over the DONE exit.
REQ-029 SHALL, without AES_INV_ABORT_EN, not have the abort port, and behaviour SHALL be exactly REQ-013..REQ-025.

Structure
REQ-030 SHALL place in shared package aes_pkg: the constant NR=10, the 128-bit state typedef, the FSM state enum, and the GF functions (xtime and multiply by 09/0b/0d/0e).
REQ-031 SHALL use one sub-module inv_sbox (8-bit in, 8-bit out, combinational inverse S-box table), instantiated 16 times.

Verification
REQ-032 SHALL test FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt_out 00112233445566778899aabbccddeeff, with out_valid exactly 10 edges after accept, and rk_idx sequence 10,9,...,1,0.
REQ-033 SHALL test all-zero key with ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> pt_out all zeros.
REQ-034 SHALL test backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and pt_out held stable; IDLE and in_ready=1 on the edge after out_ready=1.
REQ-035 SHALL test in_valid held high through an operation -> exactly one accept per IDLE visit, and the second block decrypts correctly.
REQ-036 SHALL test rst_n pulsed low at ROUND cnt=5 -> outputs return to reset values asynchronously, no out_valid for that block, and the next C.1 block passes.
REQ-037 SHALL test, with AES_INV_ABORT_EN, abort at cnt=3 -> IDLE next edge, out_valid never asserted, and the following block is correct.
